// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH,
      WAIT,
      DROP
   } fetch_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory request bus: req/gnt for the address, rvalid/rdata for the return.
interface mips_fetch_unit_if;
   import mips_pkg::*;

   logic              imem_req;
   logic [WORD_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [WORD_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/mips_inst_queue.sv
// Small FIFO of fetched {pc, inst} entries; DEPTH must be a power of two so pointers wrap naturally.
module mips_inst_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         push,
   input  fetch_entry_t                 push_entry,
   input  logic                         pop,
   input  logic                         flush,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         // Storage is left as-is; an empty count already hides it downstream.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch stage: owns the PC, keeps at most one memory read outstanding and buffers results for decode.
module mips_fetch_unit
   import mips_pkg::*;
#(
   parameter int                DEPTH    = 2,
   parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int                CNT_W    = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   mips_fetch_unit_if.master imem,
   input  logic              redirect_valid,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [WORD_W-1:0] inst_data,
   output logic [WORD_W-1:0] inst_pc,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int CW = $clog2(DEPTH+1);

   fetch_state_t      state;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] pend_pc;
   logic [CW-1:0]     q_count;
   fetch_entry_t      q_head;
   fetch_entry_t      q_in;
   logic              q_push;
   logic              q_pop;
   logic              fire;
   logic [1:0]        unused_redirect_lsb;

   assign unused_redirect_lsb = redirect_pc[1:0];

   // Gated by reset_n so the request is low while reset is held, not only after it.
   assign imem.imem_req  = reset_n && (state == FETCH) && (q_count < CW'(DEPTH)) && !redirect_valid;
   assign imem.imem_addr = pc;
   assign fire           = imem.imem_req && imem.imem_gnt;

   assign q_push = (state == WAIT) && imem.imem_rvalid && !redirect_valid;
   assign q_in   = '{pc: pend_pc, inst: imem.imem_rdata};
   assign q_pop  = inst_valid && inst_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         pend_pc   <= '0;
         stall_cnt <= '0;
      end else begin
         if (inst_ready && !inst_valid && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (redirect_valid) begin
            pc    <= {redirect_pc[WORD_W-1:2], 2'b00};
            // A read still in flight must be absorbed before fetching resumes.
            state <= ((state != FETCH) && !imem.imem_rvalid) ? DROP : FETCH;
         end else begin
            case (state)
               FETCH: if (fire) begin
                  pend_pc <= pc;
                  pc      <= pc + 32'd4;
                  state   <= WAIT;
               end
               WAIT:    if (imem.imem_rvalid) state <= FETCH;
               DROP:    if (imem.imem_rvalid) state <= FETCH;
               default: state <= FETCH;
            endcase
         end
      end
   end

   mips_inst_queue #(.DEPTH(DEPTH)) u_queue (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (q_push),
      .push_entry (q_in),
      .pop        (q_pop),
      .flush      (redirect_valid),
      .head       (q_head),
      .count      (q_count)
   );

   assign inst_valid = (q_count != '0);
   assign inst_data  = q_head.inst;
   assign inst_pc    = q_head.pc;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: table vectors, directed corner sequences and a randomized run vs a queue model.
module tb_mips_fetch_unit;

   localparam int DEPTH = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // Default-parameter instance
   logic        reset_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_ready;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [15:0] stall_cnt;
   mips_fetch_unit_if bus1 ();

   mips_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .CNT_W(16)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .imem           (bus1),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .stall_cnt      (stall_cnt)
   );

   // Narrow counter, wrapping reset PC instance
   logic        reset_n2;
   logic        redirect_valid2;
   logic [31:0] redirect_pc2;
   logic        inst_ready2;
   logic        inst_valid2;
   logic [31:0] inst_data2;
   logic [31:0] inst_pc2;
   logic [3:0]  stall_cnt2;
   mips_fetch_unit_if bus2 ();

   mips_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut2 (
      .clock          (clock),
      .reset_n        (reset_n2),
      .imem           (bus2),
      .redirect_valid (redirect_valid2),
      .redirect_pc    (redirect_pc2),
      .inst_valid     (inst_valid2),
      .inst_ready     (inst_ready2),
      .inst_data      (inst_data2),
      .inst_pc        (inst_pc2),
      .stall_cnt      (stall_cnt2)
   );

   int checks = 0;
   int errors = 0;

   // Memory behaviour and reference model state
   int          gnt_pct;
   int          spur_pct;
   bit          rand_delay;
   logic [31:0] slow_addr;
   bit          m_out;
   logic [31:0] m_addr;
   int          m_cnt;
   bit          dropping;
   logic [31:0] mpc;
   logic [31:0] mstall;
   logic [31:0] q[$];
   logic [31:0] pops[$];
   logic [31:0] popd[$];
   bit          last_gnt;
   logic [31:0] last_gnt_addr;

   logic        s_req, s_valid;
   logic [31:0] s_addr, s_pc, s_data, s_stall;

   typedef struct {
      bit          rdy;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_stall;
   } vec_t;
   vec_t tv[9];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h00E1_1820;
         32'h4:   return 32'h00E1_1822;
         32'h8:   return 32'h00E1_1824;
         32'hC:   return 32'h00E1_1825;
         default: return 32'h0800_0000 ^ a;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset(input bit check_vals);
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b0;
      bus1.imem_gnt    = 1'b0;
      bus1.imem_rvalid = 1'b0;
      bus1.imem_rdata  = '0;
      #1;
      if (check_vals) begin
         chk("rst_req",   32'(bus1.imem_req), 32'd0);
         chk("rst_addr",  bus1.imem_addr, 32'h0);
         chk("rst_valid", 32'(inst_valid), 32'd0);
         chk("rst_data",  inst_data, 32'h0);
         chk("rst_pc",    inst_pc, 32'h0);
         chk("rst_stall", 32'(stall_cnt), 32'd0);
      end
      repeat (2) @(negedge clock);
      reset_n  = 1'b1;
      m_out    = 1'b0;
      dropping = 1'b0;
      mpc      = 32'h0;
      mstall   = 0;
      q.delete();
      pops.delete();
      popd.delete();
      gnt_pct    = 100;
      spur_pct   = 0;
      rand_delay = 1'b0;
      slow_addr  = 32'hFFFF_FFFF;
   endtask

   // One cycle on the default instance: drive at negedge, sample 1ns later, advance the model.
   task automatic tick(input bit rdy, input bit redir, input logic [31:0] rp);
      bit rv, spur, g, exp_req, exp_v;
      rv   = m_out && (m_cnt <= 1);
      spur = !m_out && (spur_pct > 0) && ($urandom_range(99) < 32'(spur_pct));
      g    = ($urandom_range(99) < 32'(gnt_pct));
      bus1.imem_gnt    = g;
      bus1.imem_rvalid = rv || spur;
      bus1.imem_rdata  = rv ? mem_word(m_addr) : $urandom;
      redirect_valid   = redir;
      redirect_pc      = rp;
      inst_ready       = rdy;
      #1;
      s_req   = bus1.imem_req;
      s_addr  = bus1.imem_addr;
      s_valid = inst_valid;
      s_pc    = inst_pc;
      s_data  = inst_data;
      s_stall = 32'(stall_cnt);
      exp_req = !m_out && (q.size() < DEPTH) && !redir;
      exp_v   = (q.size() != 0);
      chk("imem_req", 32'(s_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", s_addr, mpc);
      chk("inst_valid", 32'(s_valid), 32'(exp_v));
      if (exp_v) begin
         chk("inst_pc", s_pc, q[0]);
         chk("inst_data", s_data, mem_word(q[0]));
      end
      chk("stall_cnt", s_stall, mstall);
      if (s_valid && rdy) begin
         pops.push_back(s_pc);
         popd.push_back(s_data);
      end
      if (rdy && !exp_v && mstall != 32'hFFFF) mstall++;
      if (exp_v && rdy) void'(q.pop_front());
      if (rv) begin
         m_out = 1'b0;
         if (!dropping && !redir) q.push_back(m_addr);
         dropping = 1'b0;
      end else if (m_out) begin
         m_cnt--;
      end
      if (redir) begin
         q.delete();
         mpc = {rp[31:2], 2'b00};
         if (m_out) dropping = 1'b1;
      end
      last_gnt = 1'b0;
      if (s_req && g) begin
         m_out         = 1'b1;
         m_addr        = s_addr;
         m_cnt         = rand_delay ? int'($urandom_range(3, 1)) : ((s_addr == slow_addr) ? 3 : 1);
         mpc           = mpc + 32'd4;
         last_gnt      = 1'b1;
         last_gnt_addr = s_addr;
      end
      @(negedge clock);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      // rdy, req, addr, valid, pc, stall  -- 1-cycle memory, always granted
      tv[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'd0};
      tv[1] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'd1};
      tv[2] = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h0, 32'd2};
      tv[3] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'd2};
      tv[4] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4, 32'd3};
      tv[5] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'd3};
      tv[6] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h8, 32'd4};
      tv[7] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'd4};
      tv[8] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 32'd5};

      reset_n2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0; inst_ready2 = 1'b0;
      bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0;

      @(negedge clock);
      do_reset(1'b1);

      // Streaming table
      for (int i = 0; i < 9; i++) begin
         tick(tv[i].rdy, 1'b0, 32'h0);
         chk("tv_req", 32'(s_req), 32'(tv[i].e_req));
         if (tv[i].e_req) chk("tv_addr", s_addr, tv[i].e_addr);
         chk("tv_valid", 32'(s_valid), 32'(tv[i].e_valid));
         if (tv[i].e_valid) chk("tv_pc", s_pc, tv[i].e_pc);
         chk("tv_stall", s_stall, tv[i].e_stall);
      end
      chk("tv_data0", popd[0], 32'h00E1_1820);
      chk("tv_data3", popd[3], 32'h00E1_1825);

      // Backpressure: queue fills to two entries, then requests stop
      do_reset(1'b1);
      repeat (6) tick(1'b0, 1'b0, 32'h0);
      chk("bp_req", 32'(s_req), 32'd0);
      chk("bp_valid", 32'(s_valid), 32'd1);
      chk("bp_pc", s_pc, 32'h0);
      repeat (8) tick(1'b1, 1'b0, 32'h0);
      chk("bp_pop0", pops[0], 32'h0);
      chk("bp_pop1", pops[1], 32'h4);
      chk("bp_pop2", pops[2], 32'h8);

      // Redirect while the read for 0x8 is still outstanding
      do_reset(1'b0);
      slow_addr = 32'h8;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(1'b1, 1'b0, 32'h0);
         if (last_gnt && last_gnt_addr == 32'h8) found = 1'b1;
      end
      chk("rw_gnt8_seen", 32'(found), 32'd1);
      tick(1'b1, 1'b1, 32'h40);
      pops.delete();
      popd.delete();
      for (int i = 0; i < 20 && pops.size() == 0; i++) tick(1'b1, 1'b0, 32'h0);
      chk("rw_pop_seen", 32'(pops.size() != 0), 32'd1);
      if (pops.size() != 0) begin
         chk("rw_pc", pops[0], 32'h40);
         chk("rw_data", popd[0], mem_word(32'h40));
      end

      // Redirect with a full queue and an unaligned target
      do_reset(1'b0);
      repeat (6) tick(1'b0, 1'b0, 32'h0);
      chk("rf_full", 32'(s_valid), 32'd1);
      tick(1'b0, 1'b1, 32'h103);
      tick(1'b0, 1'b0, 32'h0);
      chk("rf_valid", 32'(s_valid), 32'd0);
      chk("rf_req", 32'(s_req), 32'd1);
      chk("rf_addr", s_addr, 32'h100);

      // Randomized run against the queue model
      do_reset(1'b0);
      gnt_pct    = 60;
      spur_pct   = 10;
      rand_delay = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         bit r, rd;
         r  = ($urandom_range(99) < 75);
         rd = ($urandom_range(99) < 4);
         tick(r, rd, $urandom);
      end

      // Narrow stall counter saturates and holds
      @(negedge clock);
      reset_n2 = 1'b0;
      @(negedge clock);
      reset_n2 = 1'b1;
      inst_ready2 = 1'b1;
      bus2.imem_gnt = 1'b0;
      repeat (10) @(negedge clock);
      #1 chk("sat_10", 32'(stall_cnt2), 32'd10);
      repeat (10) @(negedge clock);
      #1 chk("sat_20", 32'(stall_cnt2), 32'd15);

      // PC wrap, then reset while a read is outstanding
      @(negedge clock);
      reset_n2 = 1'b0;
      inst_ready2 = 1'b0;
      @(negedge clock);
      reset_n2 = 1'b1;
      bus2.imem_gnt = 1'b1;
      #1;
      chk("wr_req0", 32'(bus2.imem_req), 32'd1);
      chk("wr_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
      @(negedge clock);
      #1 chk("wr_wait_req", 32'(bus2.imem_req), 32'd0);
      bus2.imem_rvalid = 1'b1;
      bus2.imem_rdata  = 32'h1234_5678;
      @(negedge clock);
      bus2.imem_rvalid = 1'b0;
      #1;
      chk("wr_req1", 32'(bus2.imem_req), 32'd1);
      chk("wr_addr1", bus2.imem_addr, 32'h0);
      chk("wr_vpc", inst_pc2, 32'hFFFF_FFFC);
      chk("wr_vdata", inst_data2, 32'h1234_5678);
      @(negedge clock);
      reset_n2 = 1'b0;
      #1;
      chk("mr_req", 32'(bus2.imem_req), 32'd0);
      chk("mr_addr", bus2.imem_addr, 32'hFFFF_FFFC);
      chk("mr_valid", 32'(inst_valid2), 32'd0);
      chk("mr_data", inst_data2, 32'h0);
      chk("mr_pc", inst_pc2, 32'h0);
      chk("mr_stall", 32'(stall_cnt2), 32'd0);
      @(negedge clock);
      reset_n2 = 1'b1;
      #1;
      chk("mr_req_after", 32'(bus2.imem_req), 32'd1);
      chk("mr_addr_after", bus2.imem_addr, 32'hFFFF_FFFC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
